serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 142 ++++++++++++++
 tb/tb_serial_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one bit per clock, LSB first
//
// Ports:
//   clk       in   single clock, rising-edge
//   reset     in   synchronous active-high reset
//   start     in   begin a new operation (ignored while busy)
//   a, b      in   WIDTH-bit operands
//   cin       in   carry-in for addition (ignored when sub=1)
//   sub       in   0: a+b+cin, 1: a-b
//   busy      out  high while bits are being processed
//   done      out  one-cycle result-valid pulse
//   sum       out  WIDTH-bit registered result
//   cout      out  carry out of the MSB (for subtraction 1 = no borrow)
//   overflow  out  two's-complement overflow of the result

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Holds the result bits produced so far; the final bit is merged in
    // directly when the result register is loaded, so only WIDTH-1 bits
    // ever need to be stored here.
    logic [WIDTH-2:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               fa_sum;
    logic               fa_carry;
    logic [WIDTH-1:0]   acc_shift;

    // Single full-adder cell working on the current LSBs of the operand shifters.
    always_comb begin
        fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
        fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        // New bit enters at the top; after WIDTH steps bit 0 sits at the LSB.
        acc_shift = {fa_sum, acc_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b once here and seed the carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                acc_d   = acc_shift[WIDTH-1:1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB, fa_carry the carry out of it.
                    sum_d   = acc_shift;
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=16)

module tb_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the effective second operand.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   s;
        logic         ov;
        bb = msub ? ~mb : mb;
        c  = msub ? 1'b1 : mcin;
        s  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c};
        ov = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
        return {ov, s};
    endfunction

    // Issue one operation; returns the edge count from the start edge to done (0 = timeout).
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                          input logic isub, output logic [W-1:0] gs, output logic gco,
                          output logic gov, output int lat);
        @(negedge clk);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        gs = sum; gco = cout; gov = overflow;
    endtask

    logic [W-1:0] gs, s1, s2;
    logic         gco, gov, c1, o1;
    logic [W+1:0] exp_r;
    int           lat, pulses, d1, d2, bad_busy;
    logic [W-1:0] ra, rb;
    logic         rcin, rsub;

    initial begin
        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        reset = 1'b1; start = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(overflow), 64'd0);
        start = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, gs, gco, gov, lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd16);
            chk($sformatf("vec%0d_sum", i), 64'(gs), 64'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 64'(gco), 64'(vecs[i].co));
            chk($sformatf("vec%0d_ovf", i), 64'(gov), 64'(vecs[i].ov));
        end

        // Second start mid-run with different operands must be ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0; lat = 0; s1 = '0; c1 = 1'b0; o1 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 6) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    lat = n; s1 = sum; c1 = cout; o1 = overflow;
                end
            end
        end
        chk("ignore_pulses", 64'(pulses), 64'd1);
        chk("ignore_lat", 64'(lat), 64'd16);
        chk("ignore_sum", 64'(s1), 64'h2345);
        chk("ignore_cout", 64'(c1), 64'd0);
        chk("ignore_ovf", 64'(o1), 64'd0);

        // Reset while bit 8 is about to be processed aborts the operation.
        @(negedge clk);
        a = 16'h00F0; b = 16'h0F00; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);

        // start held high: back-to-back operations, done pulses 17 edges apart.
        @(negedge clk);
        a = 16'h1000; b = 16'h0234; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        d1 = 0; d2 = 0; bad_busy = 0; s1 = '0; s2 = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n <= 33 && busy == done) bad_busy++;
            if (done) begin
                if (d1 == 0) begin
                    d1 = n; s1 = sum;
                    a = 16'hABCD; b = 16'h1111; sub = 1'b1;
                end else if (d2 == 0) begin
                    d2 = n; s2 = sum;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_done", 64'(d1), 64'd16);
        chk("b2b_second_done", 64'(d2), 64'd33);
        chk("b2b_first_sum", 64'(s1), 64'h1235);
        chk("b2b_second_sum", 64'(s2), 64'h9ABC);
        chk("b2b_busy_gaps", 64'(bad_busy), 64'd0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rcin = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
            exp_r = model(ra, rb, rcin, rsub);
            run_op(ra, rb, rcin, rsub, gs, gco, gov, lat);
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd16);
            chk($sformatf("rnd%0d_sum a=%0h b=%0h sub=%0d", i, ra, rb, rsub), 64'(gs), 64'(exp_r[W-1:0]));
            chk($sformatf("rnd%0d_cout", i), 64'(gco), 64'(exp_r[W]));
            chk($sformatf("rnd%0d_ovf", i), 64'(gov), 64'(exp_r[W+1]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
